// File: rtl/gpio_sample_bridge.sv
// rtl/gpio_sample_bridge.sv - GPIO synchroniser/debouncer with request or change sampling into a sequence-tagged FIFO
// Optional timestamp field enabled by defining GPIO_SAMPLE_TS_EN.
module gpio_sample_bridge #(
    parameter int IN_W       = 8,
    parameter int DATA_W     = 32,
    parameter int DEB_CYC    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_W-1:0]               gpio_in,
    input  logic                          mode,
    input  logic                          req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(DEB_CYC + 1);

`ifdef GPIO_SAMPLE_TS_EN
    if (DATA_W < IN_W + 24) begin : g_width_chk
        $error("gpio_sample_bridge: DATA_W must be >= IN_W+24 with timestamps");
    end
`else
    if (DATA_W < IN_W + 8) begin : g_width_chk
        $error("gpio_sample_bridge: DATA_W must be >= IN_W+8");
    end
`endif

    typedef enum logic {IDLE, HELD} state_t;

    logic [IN_W-1:0]   sync1, sync_val, deb_val;
    logic [CNTW-1:0]   deb_cnt;
    logic              deb_chg;
    state_t            state, state_nxt;
    logic              ev_req, ev, push, pop, full;
    logic [7:0]        seq;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] word;

    // The counter restarts on the edge that loads a new sync_val, so a clean
    // step is accepted DEB_CYC+2 edges after it reaches gpio_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync_val <= '0;
            deb_val  <= '0;
            deb_cnt  <= '0;
            deb_chg  <= 1'b0;
        end else begin
            sync1    <= gpio_in;
            sync_val <= sync1;
            deb_chg  <= 1'b0;
            if (sync1 != sync_val || sync_val == deb_val) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNTW'(DEB_CYC - 1)) begin
                deb_val <= sync_val;
                deb_cnt <= '0;
                deb_chg <= 1'b1;
            end else begin
                deb_cnt <= deb_cnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_req    = 1'b0;
        if (mode) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (req) begin
                    ev_req    = 1'b1;
                    state_nxt = HELD;
                end
                HELD: if (!req) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ev = mode ? deb_chg : ev_req;

`ifdef GPIO_SAMPLE_TS_EN
    logic [15:0] ts;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 16'd1;
    end
`endif

    always_comb begin
        word                  = '0;
        word[IN_W-1:0]        = deb_val;
        word[DATA_W-1 -: 8]   = seq;
`ifdef GPIO_SAMPLE_TS_EN
        word[IN_W +: 16]      = ts;
`endif
    end

    assign out_valid  = (count != '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = out_valid & out_ready;
    assign push       = ev & (~full | pop);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (ev)   seq    <= seq + 8'd1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            // A drop in the same cycle as a clear must stay visible.
            if (ev && full && !pop) overflow <= 1'b1;
            else if (clr_overflow)  overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_sample_bridge.sv
// tb/tb_gpio_sample_bridge.sv - directed self-checking bench for gpio_sample_bridge
module tb_gpio_sample_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gpio_in;
    logic        mode, req, out_ready, clr_overflow;
    logic        out_valid, overflow;
    logic [31:0] out_data;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

`ifdef GPIO_SAMPLE_TS_EN
    localparam logic [31:0] DMASK = 32'hFF0000FF;
`else
    localparam logic [31:0] DMASK = 32'hFFFFFFFF;
`endif

    gpio_sample_bridge #(.IN_W(8), .DATA_W(32), .DEB_CYC(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .mode(mode), .req(req),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req();
        req = 1'b1; step(1);
        req = 1'b0; step(1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1; step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gpio_in = 8'h00; mode = 1'b1; req = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        step(2);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        step(4);

        // change mode: 0x00 -> 0xA5 accepted on edge 18, pushed on edge 19
        gpio_in = 8'hA5;
        step(18);
        chk("deb_not_yet", {31'd0, out_valid}, 32'd0);
        step(1);
        chk("deb_valid", {31'd0, out_valid}, 32'd1);
        chk("deb_data", out_data & DMASK, 32'h000000A5);
        chk("deb_count", {29'd0, fifo_count}, 32'd1);
        pop_one();
        chk("pop_empty", {29'd0, fifo_count}, 32'd0);

        gpio_in = 8'hFF; step(10);
        gpio_in = 8'hA5; step(30);
        chk("glitch", {29'd0, fifo_count}, 32'd0);

        // request mode; the debounced change itself must not sample
        mode = 1'b0; gpio_in = 8'h3C;
        step(20);
        chk("req_no_chg", {29'd0, fifo_count}, 32'd0);
        req = 1'b1; step(20); req = 1'b0;
        chk("req_once", {29'd0, fifo_count}, 32'd1);
        chk("req_data1", out_data & DMASK, 32'h0100003C);
        step(1);
        pulse_req();
        chk("req_second", {29'd0, fifo_count}, 32'd2);
        pop_one();
        chk("req_data2", out_data & DMASK, 32'h0200003C);
        pop_one();

        // mode switch while HELD returns to IDLE without a sample
        req = 1'b1; step(2);
        mode = 1'b1; step(3);
        chk("mode_no_ev", {29'd0, fifo_count}, 32'd1);
        mode = 1'b0; step(1);
        chk("mode_idle", {29'd0, fifo_count}, 32'd2);
        req = 1'b0; step(1);
        chk("mode_h3", out_data & DMASK, 32'h0300003C);
        pop_one();
        chk("mode_h4", out_data & DMASK, 32'h0400003C);
        pop_one();

        // overflow: seq 5..10, only 5..8 stored
        for (int i = 0; i < 6; i++) pulse_req();
        chk("ovf_count", {29'd0, fifo_count}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_head", out_data & DMASK, {8'(5 + i), 24'h00003C});
            pop_one();
        end
        pulse_req();
        chk("ovf_gap", out_data & DMASK, 32'h0B00003C);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        pop_one();

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) pulse_req();
        req = 1'b1; clr_overflow = 1'b1; step(1);
        req = 1'b0; clr_overflow = 1'b0; step(1);
        chk("set_wins", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;

        // full FIFO: push and pop together is accepted
        req = 1'b1; out_ready = 1'b1; step(1);
        req = 1'b0; out_ready = 1'b0; step(1);
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_ovf", {31'd0, overflow}, 32'd0);
        chk("full_head", out_data & DMASK, 32'h0D00003C);

        // reset with 3 entries queued
        pop_one();
        chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
        rst = 1'b1; #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {29'd0, fifo_count}, 32'd0);
        step(1); rst = 1'b0;
        step(20);
        pulse_req();
        chk("seq_restart", out_data & DMASK, 32'h0000003C);
        pop_one();

`ifdef GPIO_SAMPLE_TS_EN
        begin
            logic [15:0] ts_a, ts_b;
            mode = 1'b1; gpio_in = 8'h11; step(100);
            gpio_in = 8'h22; step(30);
            chk("ts_count", {29'd0, fifo_count}, 32'd2);
            ts_a = out_data[23:8];
            pop_one();
            ts_b = out_data[23:8];
            pop_one();
            chk("ts_delta", {16'd0, ts_b - ts_a}, 32'd100);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
